sc_rowbank: RTL and testbench

Registered 8-row display bank that consumes the per-row 2-bit select codes produced by the game state machine and turns them into stored row patterns for the LED matrix driver. On an apply request it latches all row selects and walks the rows one per clock, clearing, holding or loading each row. Between updates it scrolls the road image down one row per scroll tick. It sits between the select-code state machine and the matrix scan/driver.

---
 rtl/sc_rowbank_pkg.sv | 32 +++
 rtl/sc_rowbank_if.sv | 36 +++
 rtl/sc_rowbank_edge.sv | 22 ++
 rtl/sc_rowbank.sv | 132 +++++++++++++
 tb/tb_sc_rowbank.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/sc_rowbank_pkg.sv
// Shared select-code and FSM state definitions for the row bank.
// The select-producing state machine uses the same codes.
package sc_rowbank_pkg;

    localparam int DEF_ROW_WIDTH    = 8;
    localparam int DEF_NUM_ROWS     = 8;
    localparam int DEF_SELECT_WIDTH = 2;

    typedef enum logic [1:0] {
        SEL_CLEAR = 2'd0,
        SEL_HOLD  = 2'd1,
        SEL_LOAD  = 2'd2,
        SEL_RSVD  = 2'd3
    } sel_code_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // The reserved code behaves exactly like HOLD, so fold it away here.
    function automatic sel_code_e decode_sel(input logic [1:0] code);
        sel_code_e c;
        c = sel_code_e'(code);
        if (c == SEL_RSVD) begin
            c = SEL_HOLD;
        end
        return c;
    endfunction

endpackage

// File: rtl/sc_rowbank_if.sv
// Bus between the select-code producer (master) and the row bank (slave).
interface sc_rowbank_if #(
    parameter int ROW_WIDTH    = 8,
    parameter int NUM_ROWS     = 8,
    parameter int SELECT_WIDTH = 2
);

    logic [NUM_ROWS*SELECT_WIDTH-1:0] SC_ROWBANK_SELECT_IN;
    logic                             SC_ROWBANK_APPLY_InLow;
    logic [ROW_WIDTH-1:0]             SC_ROWBANK_DATA_IN;
    logic                             SC_ROWBANK_SCROLL_InHigh;
    logic [NUM_ROWS*ROW_WIDTH-1:0]    SC_ROWBANK_ROWS_OUT;
    logic                             SC_ROWBANK_BUSY_OutHigh;
    logic                             SC_ROWBANK_DONE_OutHigh;

    modport master (
        output SC_ROWBANK_SELECT_IN,
        output SC_ROWBANK_APPLY_InLow,
        output SC_ROWBANK_DATA_IN,
        output SC_ROWBANK_SCROLL_InHigh,
        input  SC_ROWBANK_ROWS_OUT,
        input  SC_ROWBANK_BUSY_OutHigh,
        input  SC_ROWBANK_DONE_OutHigh
    );

    modport slave (
        input  SC_ROWBANK_SELECT_IN,
        input  SC_ROWBANK_APPLY_InLow,
        input  SC_ROWBANK_DATA_IN,
        input  SC_ROWBANK_SCROLL_InHigh,
        output SC_ROWBANK_ROWS_OUT,
        output SC_ROWBANK_BUSY_OutHigh,
        output SC_ROWBANK_DONE_OutHigh
    );

endinterface

// File: rtl/sc_rowbank_edge.sv
// Falling-edge detector for the active-low apply request.
// History resets to 1 so a low level after reset counts as a fresh request.
module sc_rowbank_edge (
    input  logic clk,
    input  logic rst,
    input  logic apply_n,
    output logic apply_evt
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= apply_n;
        end
    end

    assign apply_evt = prev_q & ~apply_n;

endmodule

// File: rtl/sc_rowbank.sv
// Registered row bank: applies latched per-row select codes one row per clock
// after an apply request, and scrolls the image down on scroll ticks when idle.
module sc_rowbank
    import sc_rowbank_pkg::*;
#(
    parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int SELECT_WIDTH = DEF_SELECT_WIDTH
) (
    input logic        SC_ROWBANK_CLOCK_50,
    input logic        SC_ROWBANK_RESET_InHigh,
    sc_rowbank_if.slave bus
);

    localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

    logic clk;
    logic rst;

    assign clk = SC_ROWBANK_CLOCK_50;
    assign rst = SC_ROWBANK_RESET_InHigh;

    state_e                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic                                pend_q, pend_d;
    logic [NUM_ROWS*SELECT_WIDTH-1:0]    sel_q;
    logic [NUM_ROWS-1:0][ROW_WIDTH-1:0]  rows_q;
    logic                                busy_q;
    logic                                done_q;

    logic                                apply_evt;
    logic                                do_latch;
    logic                                do_scroll;
    logic                                do_write;
    logic [SELECT_WIDTH-1:0]             cur_sel;

    sc_rowbank_edge u_edge (
        .clk       (clk),
        .rst       (rst),
        .apply_n   (bus.SC_ROWBANK_APPLY_InLow),
        .apply_evt (apply_evt)
    );

    assign cur_sel = sel_q[idx_q*SELECT_WIDTH +: SELECT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Apply wins over scroll in IDLE; any tick that cannot run now is remembered once.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        do_latch  = 1'b0;
        do_scroll = 1'b0;
        do_write  = 1'b0;
        case (state_q)
            IDLE: begin
                if (apply_evt) begin
                    state_d  = UPDATE;
                    idx_d    = '0;
                    do_latch = 1'b1;
                    if (bus.SC_ROWBANK_SCROLL_InHigh) begin
                        pend_d = 1'b1;
                    end
                end else if (bus.SC_ROWBANK_SCROLL_InHigh || pend_q) begin
                    do_scroll = 1'b1;
                    pend_d    = 1'b0;
                end
            end
            UPDATE: begin
                do_write = 1'b1;
                if (bus.SC_ROWBANK_SCROLL_InHigh) begin
                    pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.SC_ROWBANK_SCROLL_InHigh) begin
                    pend_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q <= '0;
            sel_q  <= '0;
        end else begin
            if (do_latch) begin
                sel_q <= bus.SC_ROWBANK_SELECT_IN;
            end
            if (do_scroll) begin
                rows_q <= {rows_q[NUM_ROWS-2:0], bus.SC_ROWBANK_DATA_IN};
            end else if (do_write) begin
                case (decode_sel(cur_sel))
                    SEL_CLEAR: rows_q[idx_q] <= '0;
                    SEL_LOAD:  rows_q[idx_q] <= bus.SC_ROWBANK_DATA_IN;
                    default:   rows_q[idx_q] <= rows_q[idx_q];
                endcase
            end
        end
    end

    assign bus.SC_ROWBANK_ROWS_OUT     = rows_q;
    assign bus.SC_ROWBANK_BUSY_OutHigh = busy_q;
    assign bus.SC_ROWBANK_DONE_OutHigh = done_q;

endmodule

// File: tb/tb_sc_rowbank.sv
// Directed self-checking bench for sc_rowbank with hand-computed row images.
module tb_sc_rowbank;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt;
    int   done_at;

    always #5 clk = ~clk;

    sc_rowbank_if #(.ROW_WIDTH(8), .NUM_ROWS(8), .SELECT_WIDTH(2)) bus ();

    sc_rowbank #(.ROW_WIDTH(8), .NUM_ROWS(8), .SELECT_WIDTH(2)) dut (
        .SC_ROWBANK_CLOCK_50     (clk),
        .SC_ROWBANK_RESET_InHigh (rst),
        .bus                     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] sel, input logic apply_n,
                                 input logic [7:0] data, input logic scroll);
        bus.SC_ROWBANK_SELECT_IN     = sel;
        bus.SC_ROWBANK_APPLY_InLow   = apply_n;
        bus.SC_ROWBANK_DATA_IN       = data;
        bus.SC_ROWBANK_SCROLL_InHigh = scroll;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full all-LOAD update; row k takes pat byte k.
    task automatic loadRows(input logic [63:0] pat);
        applyStimulus(16'hAAAA, 1'b0, pat[7:0], 1'b0);
        tick();
        bus.SC_ROWBANK_APPLY_InLow = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.SC_ROWBANK_DATA_IN = pat[k*8 +: 8];
            tick();
        end
        tick();
    endtask

    initial begin
        $display("[TB] sc_rowbank directed run");
        rst = 1'b1;
        applyStimulus(16'h0000, 1'b1, 8'h00, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_rows", bus.SC_ROWBANK_ROWS_OUT, 64'h0);
        checkOutput("reset_busy", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h0);
        checkOutput("reset_done", {63'h0, bus.SC_ROWBANK_DONE_OutHigh}, 64'h0);

        // All LOAD with DATA_IN = A0 + row, plus an ignored apply mid-update
        applyStimulus(16'hAAAA, 1'b0, 8'hA0, 1'b0);
        tick();
        checkOutput("busy_at_apply", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h1);
        bus.SC_ROWBANK_APPLY_InLow = 1'b1;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 8) bus.SC_ROWBANK_DATA_IN = 8'hA0 + 8'(k - 1);
            if (k == 2) bus.SC_ROWBANK_APPLY_InLow = 1'b0;
            if (k == 4) bus.SC_ROWBANK_APPLY_InLow = 1'b1;
            tick();
            if (bus.SC_ROWBANK_DONE_OutHigh) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 4) checkOutput("load_partial", bus.SC_ROWBANK_ROWS_OUT, 64'h00000000A3A2A1A0);
            if (k == 8) checkOutput("busy_in_done", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h1);
            if (k == 9) checkOutput("busy_after_done", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h0);
            if (k == 11) checkOutput("apply_not_queued", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h0);
        end
        checkOutput("done_count", 64'(done_cnt), 64'd1);
        checkOutput("done_edge", 64'(done_at), 64'd8);
        checkOutput("load_rows", bus.SC_ROWBANK_ROWS_OUT, 64'hA7A6A5A4A3A2A1A0);

        // Mixed codes over preloaded FF rows: row0 CLEAR, row1 HOLD, row2 LOAD, row3 RSVD
        loadRows(64'hFFFFFFFFFFFFFFFF);
        applyStimulus(16'h00E4, 1'b0, 8'h3C, 1'b0);
        tick();
        bus.SC_ROWBANK_APPLY_InLow = 1'b1;
        repeat (9) tick();
        checkOutput("mixed_rows", bus.SC_ROWBANK_ROWS_OUT, 64'h00000000FF3CFF00);

        // Single scroll tick in IDLE
        loadRows(64'h0807060504030201);
        applyStimulus(16'h00E4, 1'b1, 8'h55, 1'b1);
        tick();
        bus.SC_ROWBANK_SCROLL_InHigh = 1'b0;
        checkOutput("scroll_at_tick", bus.SC_ROWBANK_ROWS_OUT, 64'h0706050403020155);
        tick();
        checkOutput("scroll_single", bus.SC_ROWBANK_ROWS_OUT, 64'h0706050403020155);

        // Three ticks while busy collapse to one deferred scroll
        applyStimulus(16'h5555, 1'b0, 8'h99, 1'b0);
        tick();
        bus.SC_ROWBANK_APPLY_InLow = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            bus.SC_ROWBANK_SCROLL_InHigh = (k == 2 || k == 5 || k == 9);
            tick();
            if (k == 9) checkOutput("pend_not_early", bus.SC_ROWBANK_ROWS_OUT, 64'h0706050403020155);
            if (k == 10) checkOutput("pend_scroll", bus.SC_ROWBANK_ROWS_OUT, 64'h0605040302015599);
            if (k == 11) checkOutput("pend_once", bus.SC_ROWBANK_ROWS_OUT, 64'h0605040302015599);
        end

        // Apply and tick together: update first, then one scroll
        applyStimulus(16'h5555, 1'b0, 8'h77, 1'b1);
        tick();
        bus.SC_ROWBANK_APPLY_InLow   = 1'b1;
        bus.SC_ROWBANK_SCROLL_InHigh = 1'b0;
        checkOutput("apply_wins_busy", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h1);
        checkOutput("apply_wins_rows", bus.SC_ROWBANK_ROWS_OUT, 64'h0605040302015599);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 9) checkOutput("both_hold", bus.SC_ROWBANK_ROWS_OUT, 64'h0605040302015599);
            if (k == 10) checkOutput("both_scroll", bus.SC_ROWBANK_ROWS_OUT, 64'h0504030201559977);
        end

        // Reset at row 4 of an all-LOAD update with a pending tick
        applyStimulus(16'hAAAA, 1'b0, 8'hA0, 1'b0);
        tick();
        bus.SC_ROWBANK_APPLY_InLow = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.SC_ROWBANK_DATA_IN       = 8'hA0 + 8'(k - 1);
            bus.SC_ROWBANK_SCROLL_InHigh = (k == 2);
            tick();
        end
        checkOutput("rst_pre_rows", bus.SC_ROWBANK_ROWS_OUT, 64'h05040302A3A2A1A0);
        rst = 1'b1;
        bus.SC_ROWBANK_DATA_IN       = 8'hA4;
        bus.SC_ROWBANK_SCROLL_InHigh = 1'b0;
        tick();
        checkOutput("rst_mid_rows", bus.SC_ROWBANK_ROWS_OUT, 64'h0);
        checkOutput("rst_mid_busy", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h0);
        checkOutput("rst_mid_done", {63'h0, bus.SC_ROWBANK_DONE_OutHigh}, 64'h0);
        rst = 1'b0;
        bus.SC_ROWBANK_DATA_IN = 8'h55;
        done_cnt = 0;
        repeat (12) begin
            tick();
            if (bus.SC_ROWBANK_DONE_OutHigh) done_cnt++;
        end
        checkOutput("rst_no_done", 64'(done_cnt), 64'd0);
        checkOutput("rst_no_pend", bus.SC_ROWBANK_ROWS_OUT, 64'h0);
        checkOutput("rst_idle_busy", {63'h0, bus.SC_ROWBANK_BUSY_OutHigh}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
